// File: rtl/serv_rst_pkg.sv
// Shared encodings for the SERV reset sequencer: FSM states and reset-cause codes.
package serv_rst_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10
  } state_e;

  typedef logic [1:0] cause_t;

  localparam cause_t CAUSE_EXT = 2'b00;
  localparam cause_t CAUSE_SW  = 2'b01;
  localparam cause_t CAUSE_WDT = 2'b10;

endpackage : serv_rst_pkg

// File: rtl/serv_rst_wdt.sv
// Watchdog for the reset sequencer: counts while the system runs, cleared by a kick
// or whenever the sequencer is outside RUN; flags a timeout at the all-ones count.
module serv_rst_wdt #(
  parameter int unsigned WDT_W = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_kick,
  output logic o_timeout_c
);

  logic [WDT_W-1:0] cnt_q = '0;
  logic [WDT_W-1:0] cnt_d;

  // Next count: clear outside RUN or on a kick, otherwise advance.
  always_comb begin
    cnt_d = cnt_q + WDT_W'(1);
    if (!i_run || i_kick) begin
      cnt_d = '0;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A kick in the same cycle suppresses the timeout.
  assign o_timeout_c = i_run && !i_kick && (cnt_q == '1);

endmodule : serv_rst_wdt

// File: rtl/serv_rst_seq.sv
// Reset sequencer: holds all domain resets for HOLD cycles, then releases them in
// index order STAGGER cycles apart, and records the cause of the last reset.
// Optional watchdog enabled by defining SERV_RST_WDT_EN.
module serv_rst_seq
  import serv_rst_pkg::*;
#(
  parameter int unsigned HOLD     = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned STAGGER  = 4,
  parameter int unsigned WDT_W    = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_sw_rst,
  input  logic                i_wdt_kick,
  output logic [CHANNELS-1:0] o_rst,
  output logic                o_ready,
  output logic [1:0]          o_cause
);

  localparam int unsigned CNT_MAX = (HOLD > STAGGER) ? HOLD : STAGGER;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);

  // Declaration initialisers give the power-on state on FPGA targets.
  state_e              state_q = ST_ASSERT;
  logic [CNT_W-1:0]    cnt_q   = '0;
  logic [CHANNELS-1:0] rst_q   = '1;
  logic                ready_q = 1'b0;
  cause_t              cause_q = CAUSE_EXT;

  state_e              state_d;
  logic [CNT_W-1:0]    cnt_d;
  logic [CHANNELS-1:0] rst_d;
  logic                ready_d;
  cause_t              cause_d;

  logic                rel_last_c;
  logic [CHANNELS-1:0] rel_next_c;
  logic                wdt_timeout_c;

`ifdef SERV_RST_WDT_EN
  serv_rst_wdt #(
    .WDT_W (WDT_W)
  ) u_wdt (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_run       (state_q == ST_RUN),
    .i_kick      (i_wdt_kick),
    .o_timeout_c (wdt_timeout_c)
  );
`else
  logic unused_wdt_c;
  assign unused_wdt_c  = i_wdt_kick ^ (WDT_W == 0);
  assign wdt_timeout_c = 1'b0;
`endif

  // Next release pattern: one more channel drops, lowest index first; a zero
  // stagger drops every channel at once.
  always_comb begin
    rel_next_c = rst_q << 1;
    if ((STAGGER == 0) && (state_q == ST_ASSERT)) begin
      rel_next_c = '0;
    end
    rel_last_c = (rel_next_c == '0);
  end

  // Next-state and output logic; software reset beats a watchdog timeout.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    cause_d = cause_q;

    if (i_sw_rst || wdt_timeout_c) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      rst_d   = '1;
      ready_d = 1'b0;
      cause_d = i_sw_rst ? CAUSE_SW : CAUSE_WDT;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (cnt_q == HOLD_LAST) begin
            cnt_d   = '0;
            rst_d   = rel_next_c;
            ready_d = rel_last_c;
            state_d = rel_last_c ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STAG_LAST) begin
            cnt_d   = '0;
            rst_d   = rel_next_c;
            ready_d = rel_last_c;
            state_d = rel_last_c ? ST_RUN : ST_RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          cnt_d = '0;
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
          rst_d   = '1;
          ready_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; external reset has top priority.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      rst_q   <= '1;
      ready_q <= 1'b0;
      cause_q <= CAUSE_EXT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
    end
  end

  assign o_rst   = rst_q;
  assign o_ready = ready_q;
  assign o_cause = cause_q;

endmodule : serv_rst_seq

// File: tb/tb_serv_rst_seq.sv
// Directed bench for serv_rst_seq: main instance HOLD=16/CHANNELS=2/STAGGER=4/WDT_W=4,
// second instance HOLD=6/CHANNELS=3/STAGGER=0. Watchdog steps run when SERV_RST_WDT_EN is defined.
module tb_serv_rst_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       sw_rst = 1'b0;
  logic       kick = 1'b1;
  logic [1:0] rst_o;
  logic       ready_o;
  logic [1:0] cause_o;

  logic       rst0_n = 1'b1;
  logic       sw0 = 1'b0;
  logic       kick0 = 1'b1;
  logic [2:0] rst0_o;
  logic       ready0_o;
  logic [1:0] cause0_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serv_rst_seq #(.HOLD(16), .CHANNELS(2), .STAGGER(4), .WDT_W(4)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_sw_rst   (sw_rst),
    .i_wdt_kick (kick),
    .o_rst      (rst_o),
    .o_ready    (ready_o),
    .o_cause    (cause_o)
  );

  serv_rst_seq #(.HOLD(6), .CHANNELS(3), .STAGGER(0)) dut0 (
    .i_clk      (clk),
    .i_rst_n    (rst0_n),
    .i_sw_rst   (sw0),
    .i_wdt_kick (kick0),
    .o_rst      (rst0_o),
    .o_ready    (ready0_o),
    .o_cause    (cause0_o)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Power-up sequence without any i_rst_n pulse.
    #1;
    chk("por_rst", 32'(rst_o), 32'h3);
    chk("por_ready", 32'(ready_o), 32'h0);
    chk("por_cause", 32'(cause_o), 32'h0);
    tick(5);
    chk("s0_rst_e5", 32'(rst0_o), 32'h7);
    chk("s0_ready_e5", 32'(ready0_o), 32'h0);
    tick(1);
    chk("s0_rst_e6", 32'(rst0_o), 32'h0);
    chk("s0_ready_e6", 32'(ready0_o), 32'h1);
    chk("s0_cause", 32'(cause0_o), 32'h0);
    tick(9);
    chk("por_rst_e15", 32'(rst_o), 32'h3);
    tick(1);
    chk("por_rst_e16", 32'(rst_o), 32'h2);
    chk("por_ready_e16", 32'(ready_o), 32'h0);
    tick(3);
    chk("por_rst_e19", 32'(rst_o), 32'h2);
    chk("por_ready_e19", 32'(ready_o), 32'h0);
    tick(1);
    chk("por_rst_e20", 32'(rst_o), 32'h0);
    chk("por_ready_e20", 32'(ready_o), 32'h1);
    chk("por_cause_e20", 32'(cause_o), 32'h0);

    // Software reset from RUN.
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    chk("sw_rst", 32'(rst_o), 32'h3);
    chk("sw_ready", 32'(ready_o), 32'h0);
    chk("sw_cause", 32'(cause_o), 32'h1);
    tick(15);
    chk("sw_rst_15", 32'(rst_o), 32'h3);
    tick(1);
    chk("sw_rst_16", 32'(rst_o), 32'h2);
    chk("sw_cause_16", 32'(cause_o), 32'h1);
    tick(4);
    chk("sw_rst_20", 32'(rst_o), 32'h0);
    chk("sw_ready_20", 32'(ready_o), 32'h1);
    chk("sw_cause_20", 32'(cause_o), 32'h1);

    // Software reset during ASSERT restarts the full hold.
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    tick(5);
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    chk("sw2_rst", 32'(rst_o), 32'h3);
    tick(15);
    chk("sw2_rst_15", 32'(rst_o), 32'h3);
    tick(1);
    chk("sw2_rst_16", 32'(rst_o), 32'h2);

    // External reset low for three cycles during RELEASE.
    rst_n = 1'b0;
    tick(1);
    chk("ext_rst", 32'(rst_o), 32'h3);
    chk("ext_ready", 32'(ready_o), 32'h0);
    chk("ext_cause", 32'(cause_o), 32'h0);
    tick(2);
    chk("ext_rst_held", 32'(rst_o), 32'h3);
    rst_n = 1'b1;
    tick(15);
    chk("ext_rst_15", 32'(rst_o), 32'h3);
    tick(1);
    chk("ext_rst_16", 32'(rst_o), 32'h2);
    tick(2);
    chk("ext_rst_18", 32'(rst_o), 32'h2);
    tick(2);
    chk("ext_rst_20", 32'(rst_o), 32'h0);
    chk("ext_ready_20", 32'(ready_o), 32'h1);
    chk("ext_cause_20", 32'(cause_o), 32'h0);

`ifdef SERV_RST_WDT_EN
    // No kicks: timeout after the counter reaches 15.
    kick = 1'b0;
    tick(15);
    chk("wdt_pre_rst", 32'(rst_o), 32'h0);
    chk("wdt_pre_ready", 32'(ready_o), 32'h1);
    tick(1);
    chk("wdt_rst", 32'(rst_o), 32'h3);
    chk("wdt_ready", 32'(ready_o), 32'h0);
    chk("wdt_cause", 32'(cause_o), 32'h2);
    kick = 1'b1;
    tick(20);
    chk("wdt_rel_ready", 32'(ready_o), 32'h1);

    // Kick every 10 cycles keeps the system running for 200 cycles.
    for (int i = 0; i < 20; i++) begin
      kick = 1'b0;
      tick(9);
      kick = 1'b1;
      tick(1);
      chk("wdt_kick_ready", 32'(ready_o), 32'h1);
    end

    // Software reset on the timeout cycle wins.
    kick = 1'b0;
    tick(15);
    sw_rst = 1'b1;
    tick(1);
    sw_rst = 1'b0;
    chk("wdt_sw_rst", 32'(rst_o), 32'h3);
    chk("wdt_sw_cause", 32'(cause_o), 32'h1);
    kick = 1'b1;
    tick(20);
    chk("wdt_sw_ready", 32'(ready_o), 32'h1);

    // Kick on the timeout cycle suppresses the reset.
    kick = 1'b0;
    tick(15);
    kick = 1'b1;
    tick(1);
    chk("wdt_kick_tmo_rst", 32'(rst_o), 32'h0);
    chk("wdt_kick_tmo_ready", 32'(ready_o), 32'h1);
    tick(5);
    chk("wdt_kick_tmo_cause", 32'(cause_o), 32'h1);
    chk("wdt_kick_tmo_ready2", 32'(ready_o), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serv_rst_seq
